// File: rtl/btn_debounce_pkg.sv
// Shared constants for the push-button debouncer feeding the lab full adder.
package btn_debounce_pkg;

    localparam int unsigned BTN_ADDEND = 0;
    localparam int unsigned BTN_AUGEND = 1;
    localparam int unsigned BTN_CARRY  = 2;

    localparam int unsigned DEBOUNCE_CYCLES_DEFAULT = 240000;
    localparam int unsigned DEBOUNCE_CYCLES_SIM     = 4;

endpackage

// File: rtl/btn_debounce_if.sv
// Button bundle between the board pins / consumers and the debouncer.
interface btn_debounce_if #(
    parameter int unsigned NUM_BTN = 3
);
    logic [NUM_BTN-1:0] btn_raw;
    logic [NUM_BTN-1:0] btn_level;
    logic [NUM_BTN-1:0] btn_press;
    logic [NUM_BTN-1:0] btn_release;
    logic               any_change;

    modport master (
        output btn_raw,
        input  btn_level,
        input  btn_press,
        input  btn_release,
        input  any_change
    );

    modport slave (
        input  btn_raw,
        output btn_level,
        output btn_press,
        output btn_release,
        output any_change
    );
endinterface

// File: rtl/btn_debounce_chan.sv
// One debounce channel: 2-FF synchroniser, stability counter, level and edge pulses.
module debounce_chan #(
    parameter int unsigned DEBOUNCE_CYCLES = 4,
    parameter int unsigned CNT_W           = $clog2(DEBOUNCE_CYCLES)
) (
    input  logic clk,
    input  logic rst,
    input  logic i_n,
    output logic o_level,
    output logic o_press,
    output logic o_release,
    output logic o_fire_c
);
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DEBOUNCE_CYCLES - 1);

    logic             r_s1;
    logic             r_s2;
    logic [CNT_W-1:0] r_cnt;
    logic             r_level;
    logic             r_press;
    logic             r_release;
    logic             w_diff;
    logic             w_done;

    assign w_diff   = (r_s2 != r_level);
    assign w_done   = w_diff && (r_cnt == CNT_MAX);
    assign o_fire_c = w_done;

    // Any return of s2 to the accepted level restarts the qualification window.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_s1      <= 1'b0;
            r_s2      <= 1'b0;
            r_cnt     <= '0;
            r_level   <= 1'b0;
            r_press   <= 1'b0;
            r_release <= 1'b0;
        end else begin
            r_s1 <= i_n;
            r_s2 <= r_s1;
            if (!w_diff) begin
                r_cnt     <= '0;
                r_press   <= 1'b0;
                r_release <= 1'b0;
            end else if (!w_done) begin
                r_cnt     <= r_cnt + CNT_W'(1);
                r_press   <= 1'b0;
                r_release <= 1'b0;
            end else begin
                r_level   <= r_s2;
                r_cnt     <= '0;
                r_press   <= r_s2;
                r_release <= ~r_s2;
            end
        end
    end

    assign o_level   = r_level;
    assign o_press   = r_press;
    assign o_release = r_release;

endmodule

// File: rtl/btn_debounce.sv
// Multi-channel button conditioner: polarity normalisation, per-channel debounce, change flag.
module btn_debounce
    import btn_debounce_pkg::*;
#(
    parameter int unsigned NUM_BTN         = 3,
    parameter int unsigned DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEFAULT,
    parameter bit          BTN_ACTIVE_LOW  = 1'b0
) (
    input  logic                 clk,
    input  logic                 rst,
    btn_debounce_if.slave        bus
);
    localparam int unsigned        CNT_W    = $clog2(DEBOUNCE_CYCLES);
    localparam logic [NUM_BTN-1:0] POL_MASK = {NUM_BTN{BTN_ACTIVE_LOW}};

    logic [NUM_BTN-1:0] w_norm;
    logic [NUM_BTN-1:0] w_level;
    logic [NUM_BTN-1:0] w_press;
    logic [NUM_BTN-1:0] w_release;
    logic [NUM_BTN-1:0] w_fire;
    logic               r_any_change;

    assign w_norm = bus.btn_raw ^ POL_MASK;

    for (genvar gi = 0; gi < NUM_BTN; gi++) begin : g_chan
        debounce_chan #(
            .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
            .CNT_W           (CNT_W)
        ) u_chan (
            .clk       (clk),
            .rst       (rst),
            .i_n       (w_norm[gi]),
            .o_level   (w_level[gi]),
            .o_press   (w_press[gi]),
            .o_release (w_release[gi]),
            .o_fire_c  (w_fire[gi])
        );
    end

    // Registered alongside the channel pulses so it lands in the same cycle.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_any_change <= 1'b0;
        end else begin
            r_any_change <= |w_fire;
        end
    end

    assign bus.btn_level   = w_level;
    assign bus.btn_press   = w_press;
    assign bus.btn_release = w_release;
    assign bus.any_change  = r_any_change;

endmodule
